// File: rtl/bubsysrom_sram_dma.sv
// Fill/copy bus master for the single-port on-chip SRAM (registered read, 1-cycle latency).
// Optional abort input is compiled in with `define BUBSYSROM_SRAM_DMA_ABORT_EN.
module bubsysrom_sram_dma #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    input  logic          i_START,
    input  logic          i_MODE,
    input  logic [AW-1:0] i_SRC_ADDR,
    input  logic [AW-1:0] i_DST_ADDR,
    input  logic [AW-1:0] i_LEN,
    input  logic [DW-1:0] i_FILL_DATA,
`ifdef BUBSYSROM_SRAM_DMA_ABORT_EN
    input  logic          i_ABORT,
`endif
    output logic          o_BUSY,
    output logic          o_DONE,
    output logic [AW-1:0] o_SRAM_ADDR,
    output logic [DW-1:0] o_SRAM_DIN,
    output logic          o_SRAM_RD,
    output logic          o_SRAM_WR,
    input  logic [DW-1:0] i_SRAM_DOUT
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_HOLD, S_WR, S_DONE} state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);

    state_t        r_state, w_state;
    logic [AW-1:0] r_src, w_src, r_dst, w_dst, r_cnt, w_cnt, r_addr, w_addr;
    logic [DW-1:0] r_fill, w_fill, r_din, w_din;
    logic          r_rd, w_rd, r_wr, w_wr, r_done, w_done, r_busy, w_busy;
    logic          w_abort;

`ifdef BUBSYSROM_SRAM_DMA_ABORT_EN
    assign w_abort = i_ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // Bus outputs are registered: the values computed here appear during the
    // cycle in which r_state equals w_state. r_cnt counts words still to issue
    // after the one currently on the bus.
    always_comb begin
        w_state = r_state;
        w_src   = r_src;
        w_dst   = r_dst;
        w_cnt   = r_cnt;
        w_fill  = r_fill;
        w_addr  = r_addr;
        w_din   = r_din;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_done  = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_IDLE: if (i_START) begin
                w_fill = i_FILL_DATA;
                w_src  = i_SRC_ADDR;
                w_dst  = i_DST_ADDR;
                w_cnt  = i_LEN;
                if (i_LEN == '0) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else if (!i_MODE) begin
                    w_state = S_FILL;
                    w_wr    = 1'b1;
                    w_addr  = i_DST_ADDR;
                    w_din   = i_FILL_DATA;
                    w_dst   = i_DST_ADDR + A_ONE;
                    w_cnt   = i_LEN - A_ONE;
                    w_busy  = 1'b1;
                end else begin
                    w_state = S_RD;
                    w_rd    = 1'b1;
                    w_addr  = i_SRC_ADDR;
                    w_src   = i_SRC_ADDR + A_ONE;
                    w_cnt   = i_LEN - A_ONE;
                    w_busy  = 1'b1;
                end
            end
            S_FILL: begin
                if (w_abort || r_cnt == '0) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_wr   = 1'b1;
                    w_addr = r_dst;
                    w_din  = r_fill;
                    w_dst  = r_dst + A_ONE;
                    w_cnt  = r_cnt - A_ONE;
                    w_busy = 1'b1;
                end
            end
            S_RD: begin
                if (w_abort) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_HOLD;
                    w_busy  = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_abort) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    // Read data is valid now; it goes straight into the DIN register.
                    w_state = S_WR;
                    w_wr    = 1'b1;
                    w_addr  = r_dst;
                    w_din   = i_SRAM_DOUT;
                    w_dst   = r_dst + A_ONE;
                    w_busy  = 1'b1;
                end
            end
            S_WR: begin
                if (w_abort || r_cnt == '0) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_RD;
                    w_rd    = 1'b1;
                    w_addr  = r_src;
                    w_src   = r_src + A_ONE;
                    w_cnt   = r_cnt - A_ONE;
                    w_busy  = 1'b1;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_fill  <= w_fill;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign o_BUSY      = r_busy;
    assign o_DONE      = r_done;
    assign o_SRAM_ADDR = r_addr;
    assign o_SRAM_DIN  = r_din;
    assign o_SRAM_RD   = r_rd;
    assign o_SRAM_WR   = r_wr;

endmodule
